// File: rtl/rv_rom_arbiter_if.sv
// Request/response channels for the instruction-fetch (I) and data-load (D)
// ports of the ROM arbiter.
interface rv_rom_arbiter_if;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] i_rsp_data;
  logic        i_rsp_err;

  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_req_addr;
  logic        d_rsp_valid;
  logic        d_rsp_ready;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;

  modport master (
    output i_req_valid, i_req_addr, i_rsp_ready,
    output d_req_valid, d_req_addr, d_rsp_ready,
    input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_rsp_ready,
    input  d_req_valid, d_req_addr, d_rsp_ready,
    output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err
  );
endinterface

// File: rtl/rv_rom_arbiter.sv
// Round-robin arbiter sharing a 1-cycle-latency ROM between instruction fetch
// and data loads, with buffered responses and misaligned/out-of-range errors.
module rv_rom_arbiter #(
  parameter int unsigned WORDS     = 4096,
  parameter int unsigned AW        = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  rv_rom_arbiter_if.slave      bus,
  output logic [AW-1:0]        rom_addr,
  input  logic [31:0]          rom_rdata,
  output logic                 rom_we
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP} state_e;

  localparam logic [32:0] LIMIT = 33'(WORDS) * 33'd4;

  state_e        state_q, state_d;
  logic          own_d_q, own_d_d;      // 1: D port owns the transaction
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          last_d_q, last_d_d;    // 1: D was granted last
  logic          i_rsp_valid_q, i_rsp_valid_d;
  logic          i_rsp_err_q, i_rsp_err_d;
  logic [31:0]   i_rsp_data_q, i_rsp_data_d;
  logic          d_rsp_valid_q, d_rsp_valid_d;
  logic          d_rsp_err_q, d_rsp_err_d;
  logic [31:0]   d_rsp_data_q, d_rsp_data_d;

  logic          gnt_i, gnt_d;
  logic [31:0]   req_addr, off;
  logic          req_err;

  always_comb begin
    state_d       = state_q;
    own_d_d       = own_d_q;
    err_d         = err_q;
    addr_d        = addr_q;
    last_d_d      = last_d_q;
    i_rsp_valid_d = i_rsp_valid_q;
    i_rsp_err_d   = i_rsp_err_q;
    i_rsp_data_d  = i_rsp_data_q;
    d_rsp_valid_d = d_rsp_valid_q;
    d_rsp_err_d   = d_rsp_err_q;
    d_rsp_data_d  = d_rsp_data_q;
    gnt_i         = 1'b0;
    gnt_d         = 1'b0;
    rom_addr      = addr_q;

    // Tie goes to whichever port was not granted last.
    if (state_q == S_IDLE) begin
      gnt_i = bus.i_req_valid && (!bus.d_req_valid || last_d_q);
      gnt_d = bus.d_req_valid && !gnt_i;
    end
    req_addr = gnt_d ? bus.d_req_addr : bus.i_req_addr;
    off      = req_addr - BASE_ADDR;
    req_err  = (req_addr[1:0] != 2'b00) || ({1'b0, off} >= LIMIT);

    case (state_q)
      S_IDLE: begin
        if (gnt_i || gnt_d) begin
          rom_addr = AW'(off >> 2);
          addr_d   = AW'(off >> 2);
          own_d_d  = gnt_d;
          err_d    = req_err;
          last_d_d = gnt_d;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        if (own_d_q) begin
          d_rsp_valid_d = 1'b1;
          d_rsp_err_d   = err_q;
          d_rsp_data_d  = err_q ? '0 : rom_rdata;
        end else begin
          i_rsp_valid_d = 1'b1;
          i_rsp_err_d   = err_q;
          i_rsp_data_d  = err_q ? '0 : rom_rdata;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (own_d_q && bus.d_rsp_ready) begin
          d_rsp_valid_d = 1'b0;
          d_rsp_err_d   = 1'b0;
          state_d       = S_IDLE;
        end else if (!own_d_q && bus.i_rsp_ready) begin
          i_rsp_valid_d = 1'b0;
          i_rsp_err_d   = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      own_d_q       <= 1'b0;
      err_q         <= 1'b0;
      addr_q        <= '0;
      last_d_q      <= 1'b1;
      i_rsp_valid_q <= 1'b0;
      i_rsp_err_q   <= 1'b0;
      i_rsp_data_q  <= '0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_err_q   <= 1'b0;
      d_rsp_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      own_d_q       <= own_d_d;
      err_q         <= err_d;
      addr_q        <= addr_d;
      last_d_q      <= last_d_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      i_rsp_err_q   <= i_rsp_err_d;
      i_rsp_data_q  <= i_rsp_data_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      d_rsp_err_q   <= d_rsp_err_d;
      d_rsp_data_q  <= d_rsp_data_d;
    end
  end

  assign bus.i_req_ready = gnt_i;
  assign bus.d_req_ready = gnt_d;
  assign bus.i_rsp_valid = i_rsp_valid_q;
  assign bus.i_rsp_err   = i_rsp_err_q;
  assign bus.i_rsp_data  = i_rsp_data_q;
  assign bus.d_rsp_valid = d_rsp_valid_q;
  assign bus.d_rsp_err   = d_rsp_err_q;
  assign bus.d_rsp_data  = d_rsp_data_q;
  assign rom_we          = 1'b0;

endmodule

// File: tb/tb_rv_rom_arbiter.sv
// Randomised and directed checks of rv_rom_arbiter against a transaction-level
// model; a second instance exercises a non-zero BASE_ADDR.
module tb_rv_rom_arbiter;
  logic        clk;
  logic        rst;
  logic [11:0] rom1_addr, rom2_addr;
  logic [31:0] rom1_rdata, rom2_rdata;
  logic        rom1_we, rom2_we;
  logic [31:0] mem [0:4095];

  int total = 0;
  int bad   = 0;

  rv_rom_arbiter_if bus1();
  rv_rom_arbiter_if bus2();

  rv_rom_arbiter #(.WORDS(4096), .AW(12), .BASE_ADDR(32'h0000_0000)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .rom_addr(rom1_addr), .rom_rdata(rom1_rdata), .rom_we(rom1_we)
  );

  rv_rom_arbiter #(.WORDS(4096), .AW(12), .BASE_ADDR(32'h0001_0000)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .rom_addr(rom2_addr), .rom_rdata(rom2_rdata), .rom_we(rom2_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: registered read, one cycle latency.
  always @(posedge clk) begin
    rom1_rdata <= mem[rom1_addr];
    rom2_rdata <= mem[rom2_addr];
  end

  // Transaction-level model of dut1 (BASE 0, 4096 words).
  int          cyc = 0;
  bit          m_pend;
  int          m_t;
  bit          m_port_d;
  bit          m_err;
  logic [31:0] m_data;
  bit          m_last_d;
  logic [11:0] m_addr_reg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_cycle();
    bit          e_ir, e_dr, e_iv, e_dv;
    logic [11:0] e_rom;
    logic [31:0] a, off, w;
    if (rst) begin
      m_pend = 0; m_last_d = 1; m_addr_reg = '0;
      cyc++;
      return;
    end
    e_ir = 0; e_dr = 0; e_iv = 0; e_dv = 0;
    e_rom = m_addr_reg;
    a = 0; off = 0;
    if (!m_pend) begin
      if (bus1.i_req_valid && (!bus1.d_req_valid || m_last_d)) e_ir = 1;
      else if (bus1.d_req_valid) e_dr = 1;
      if (e_ir || e_dr) begin
        a = e_dr ? bus1.d_req_addr : bus1.i_req_addr;
        off = a - 32'h0;
        w = off / 4;
        e_rom = w[11:0];
      end
    end else if (cyc - m_t >= 2) begin
      if (m_port_d) e_dv = 1; else e_iv = 1;
    end
    chk("i_req_ready", bus1.i_req_ready, e_ir);
    chk("d_req_ready", bus1.d_req_ready, e_dr);
    chk("rom_addr", rom1_addr, e_rom);
    chk("rom_we", rom1_we, 0);
    chk("i_rsp_valid", bus1.i_rsp_valid, e_iv);
    chk("d_rsp_valid", bus1.d_rsp_valid, e_dv);
    chk("i_rsp_err", bus1.i_rsp_err, e_iv ? m_err : 1'b0);
    chk("d_rsp_err", bus1.d_rsp_err, e_dv ? m_err : 1'b0);
    if (e_iv) chk("i_rsp_data", bus1.i_rsp_data, m_data);
    if (e_dv) chk("d_rsp_data", bus1.d_rsp_data, m_data);
    if (e_ir || e_dr) begin
      m_pend = 1; m_t = cyc; m_port_d = e_dr; m_last_d = e_dr; m_addr_reg = e_rom;
      m_err  = (a % 4 != 0) || (off >= 32'd16384);
      m_data = m_err ? 32'h0 : mem[off / 4];
    end else if (m_pend && (cyc - m_t >= 2) &&
                 (m_port_d ? bus1.d_rsp_ready : bus1.i_rsp_ready)) begin
      m_pend = 0;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input logic [31:0] ia, input bit irr,
                       input bit dv, input logic [31:0] da, input bit drr);
    bus1.i_req_valid = iv; bus1.i_req_addr = ia; bus1.i_rsp_ready = irr;
    bus1.d_req_valid = dv; bus1.d_req_addr = da; bus1.d_rsp_ready = drr;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: rand_addr = $urandom_range(0, 4095) * 4;
      3:       rand_addr = $urandom_range(0, 4095) * 4 + $urandom_range(1, 3);
      4:       rand_addr = 32'h4000 + $urandom_range(0, 1000) * 4;
      default: begin
        case ($urandom_range(0, 2))
          0:       rand_addr = 32'h0000_3FFC;
          1:       rand_addr = 32'h0000_4000;
          default: rand_addr = 32'hFFFF_FFFC;
        endcase
      end
    endcase
  endfunction

  string gseq;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[2] = 32'hDEAD_BEEF;
    rst = 1;
    drive(0, 0, 1, 0, 0, 1);
    bus2.i_req_valid = 0; bus2.i_req_addr = 0; bus2.i_rsp_ready = 1;
    bus2.d_req_valid = 0; bus2.d_req_addr = 0; bus2.d_rsp_ready = 1;
    m_pend = 0; m_last_d = 1; m_addr_reg = '0; m_t = 0;
    m_port_d = 0; m_err = 0; m_data = 0;
    @(posedge clk); #1;
    do_reset();

    // Reset values
    #1;
    chk("rst_i_rsp_valid", bus1.i_rsp_valid, 0);
    chk("rst_d_rsp_valid", bus1.d_rsp_valid, 0);
    chk("rst_i_rsp_data", bus1.i_rsp_data, 0);
    chk("rst_d_rsp_data", bus1.d_rsp_data, 0);
    chk("rst_rom_addr", rom1_addr, 0);
    chk("rst_rom_we", rom1_we, 0);
    tick();

    // Basic fetch at 0x8
    drive(1, 32'h8, 1, 0, 0, 1); #1;
    chk("t1_i_req_ready", bus1.i_req_ready, 1);
    chk("t1_rom_addr", rom1_addr, 2);
    tick();
    drive(0, 0, 1, 0, 0, 1); #1;
    chk("t1_no_early_rsp", bus1.i_rsp_valid, 0);
    tick(); #1;
    chk("t1_i_rsp_valid", bus1.i_rsp_valid, 1);
    chk("t1_i_rsp_data", bus1.i_rsp_data, 32'hDEAD_BEEF);
    chk("t1_i_rsp_err", bus1.i_rsp_err, 0);
    tick();
    drive(1, 32'hC, 1, 0, 0, 1); #1;
    chk("t1_idle_again", bus1.i_req_ready, 1);
    tick();
    drive(0, 0, 1, 0, 0, 1);
    repeat (3) tick();

    // Alternating grants after reset: I first
    do_reset();
    gseq = "";
    drive(1, 32'h0, 1, 1, 32'h4, 1);
    for (int k = 0; k < 12; k++) begin
      #1;
      if (bus1.i_req_ready) gseq = {gseq, "I"};
      if (bus1.d_req_ready) gseq = {gseq, "D"};
      tick();
    end
    total++;
    if (gseq != "IDID") begin
      bad++;
      $display("FAIL grant_order: got %s expected IDID", gseq);
    end
    drive(0, 0, 1, 0, 0, 1);
    repeat (3) tick();

    // Misaligned and out-of-range D requests
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 1, 1, (k == 0) ? 32'h6 : 32'h4000, 1); #1;
      chk("t3_d_req_ready", bus1.d_req_ready, 1);
      tick();
      drive(0, 0, 1, 0, 0, 1);
      tick(); #1;
      chk("t3_d_rsp_valid", bus1.d_rsp_valid, 1);
      chk("t3_d_rsp_err", bus1.d_rsp_err, 1);
      chk("t3_d_rsp_data", bus1.d_rsp_data, 0);
      tick();
    end

    // I response back-pressured while D waits
    drive(1, 32'h10, 0, 1, 32'h20, 1); #1;
    chk("t4_i_granted", bus1.i_req_ready, 1);
    tick();
    drive(0, 0, 0, 1, 32'h20, 1);
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_hold_valid", bus1.i_rsp_valid, 1);
      chk("t4_hold_data", bus1.i_rsp_data, mem[4]);
      chk("t4_d_blocked", bus1.d_req_ready, 0);
      tick();
    end
    drive(0, 0, 1, 1, 32'h20, 1); #1;
    chk("t4_d_blocked_hs", bus1.d_req_ready, 0);
    tick(); #1;
    chk("t4_d_granted", bus1.d_req_ready, 1);
    tick();
    drive(0, 0, 1, 0, 0, 1);
    repeat (3) tick();

    // Reset during READ drops the transaction
    drive(1, 32'h8, 1, 0, 0, 1);
    tick();
    drive(0, 0, 1, 0, 0, 1);
    rst = 1;
    tick();
    rst = 0; #1;
    chk("t5_i_rsp_valid", bus1.i_rsp_valid, 0);
    chk("t5_i_rsp_data", bus1.i_rsp_data, 0);
    chk("t5_rom_addr", rom1_addr, 0);
    repeat (4) tick();
    drive(1, 32'h4, 1, 1, 32'h8, 1); #1;
    chk("t5_i_first", bus1.i_req_ready, 1);
    chk("t5_d_not", bus1.d_req_ready, 0);
    tick();
    drive(0, 0, 1, 0, 0, 1);
    repeat (3) tick();

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) < 6, rand_addr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) < 6, rand_addr(), $urandom_range(0, 3) != 0);
      tick();
    end
    rst = 0;
    drive(0, 0, 1, 0, 0, 1);
    repeat (4) tick();

    // Non-zero BASE_ADDR instance
    bus2.i_req_valid = 1; bus2.i_req_addr = 32'h0001_0010; #1;
    chk("b_ready", bus2.i_req_ready, 1);
    chk("b_rom_addr", rom2_addr, 4);
    tick();
    bus2.i_req_valid = 0;
    tick(); #1;
    chk("b_valid", bus2.i_rsp_valid, 1);
    chk("b_err", bus2.i_rsp_err, 0);
    chk("b_data", bus2.i_rsp_data, mem[4]);
    chk("b_rom_we", rom2_we, 0);
    tick();
    bus2.i_req_valid = 1; bus2.i_req_addr = 32'h0000_FFFC; #1;
    chk("b_low_ready", bus2.i_req_ready, 1);
    tick();
    bus2.i_req_valid = 0;
    tick(); #1;
    chk("b_low_valid", bus2.i_rsp_valid, 1);
    chk("b_low_err", bus2.i_rsp_err, 1);
    chk("b_low_data", bus2.i_rsp_data, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv_rom_arbiter.md
Name: rv_rom_arbiter

Overview:
- Shares the single-port, 1-cycle-latency instruction/firmware ROM between two requesters: instruction fetch (I port) and data loads (D port).
- Converts byte addresses to word addresses and arbitrates round-robin between the two ports.
- Sequences each ROM read and returns data through buffered valid/ready response channels.
- Flags misaligned and out-of-range accesses with an error response.
- Sits between the core's fetch/load units and the ROM.

Parameters:
- WORDS, 4096, ROM depth in 32-bit words.
- AW, 12, ROM word-address width; must satisfy 2**AW >= WORDS.
- BASE_ADDR, 32'h0000_0000, byte address of ROM word 0; must be 4-byte aligned.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- i_req_valid  input  1  fetch request valid.
- i_req_ready  output  1  fetch request accepted this cycle.
- i_req_addr  input  32  fetch byte address.
- i_rsp_valid  output  1  fetch response valid.
- i_rsp_ready  input  1  fetch response consumed.
- i_rsp_data  output  32  fetch read data.
- i_rsp_err  output  1  fetch access error.
- d_req_valid, d_req_ready, d_req_addr, d_rsp_valid, d_rsp_ready, d_rsp_data, d_rsp_err  same directions and widths as the I port; data-load channel.
- rom_addr  output  AW  word address to ROM.
- rom_rdata  input  32  ROM data, valid one cycle after rom_addr is sampled.
- rom_we  output  1  ROM write enable; constant 0.

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - state=IDLE.
  - All *_req_ready, *_rsp_valid and *_rsp_err = 0.
  - *_rsp_data = 0 and rom_addr = 0.
  - Round-robin pointer last_grant = D, so I wins the first tie.
  - Reset mid-transaction drops the transaction; no response is ever issued for it.
- States:
  - IDLE: waiting for a request.
  - READ: ROM access in flight; owner and error flag are registered.
  - RESP: response held on the owner's channel.
- IDLE:
  - If exactly one port's req_valid=1, that port is granted.
  - If both are valid, grant the port not equal to last_grant.
  - Granted port sees req_ready=1 combinationally in the same cycle; the other port's ready stays 0.
  - rom_addr = (req_addr - BASE_ADDR) >> 2, truncated to AW bits, driven combinationally.
  - When no request is valid, rom_addr holds its last registered value.
  - On the handshake edge: register owner, addr and err; update last_grant; go to READ.
- Error condition, evaluated at grant:
  - req_addr[1:0] != 0, or
  - (req_addr - BASE_ADDR) >= WORDS*4, using unsigned 32-bit wrap (an address below BASE_ADDR wraps large and is an error).
  - An erroring request is still accepted and takes the same latency.
- READ (exactly 1 cycle):
  - rom_addr holds the registered address.
  - At the edge, capture the owner's rsp_data: rom_rdata, or 0 if err.
  - Capture rsp_err = err; go to RESP.
- RESP:
  - Owner's rsp_valid=1; rsp_data and rsp_err stay stable until the rsp handshake.
  - The non-owner's rsp_valid stays 0.
  - On rsp_valid & rsp_ready: clear rsp_valid and rsp_err; go to IDLE.
  - No request is accepted in RESP.
- Latency and throughput:
  - Request handshake in cycle N gives rsp_valid first high in cycle N+2.
  - Maximum throughput is one transaction per 3 cycles.
- Requesters may hold or change req_addr/req_valid freely while not ready; only the handshake cycle matters.
- At most one transaction is outstanding in total; neither port is ever granted twice while a response is pending.
- rom_we is 0 at all times, including during reset.

Test Plan:
- Reset, then I request at addr 0x0000_0008 with ROM word 2 = 0xDEADBEEF and i_rsp_ready=1 -> i_req_ready high in cycle 0, rom_addr=2, i_rsp_valid in cycle 2 with data 0xDEADBEEF and err=0, back in IDLE in cycle 3.
- I and D both valid every cycle (I addr 0x0, D addr 0x4), both rsp_ready=1 -> grants alternate I,D,I,D with I first; each response carries the correct word; d_rsp_valid is never high in the same cycle as i_rsp_valid.
- D request at 0x0000_0006 (misaligned) and at 0x0000_4000 with WORDS=4096 (out of range) -> each gets d_rsp_valid with d_rsp_err=1 and d_rsp_data=0 at N+2.
- I response with i_rsp_ready held 0 for 5 cycles while D is valid -> i_rsp_valid and data stay stable, d_req_ready stays 0 throughout; D is granted the cycle after the I response handshake.
- rst asserted in READ state -> next cycle all outputs are at reset values, no response is issued, and a new I request is granted first.
- BASE_ADDR=32'h0001_0000: request at 0x0001_0010 -> rom_addr=4, err=0; request at 0x0000_FFFC -> err=1.
